// File: rtl/l1_readout_pkg.sv
// rtl/l1_readout_pkg.sv - shared types and widths for the L1 accept readout
package l1_readout_pkg;

    localparam int SAMPLE_W = 8;
    localparam int EVT_BX_W = 12;
    localparam int LOST_W   = 8;
    localparam logic [LOST_W-1:0] LOST_MAX = '1;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        IDLE   = 2'd1,
        DEAD   = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] energy;
        logic signed [SAMPLE_W-1:0] isol;
        logic [EVT_BX_W-1:0]        bx;
    } event_t;

endpackage

// File: rtl/l1_derand_fifo.sv
// rtl/l1_derand_fifo.sv - first-word-fall-through derandomiser FIFO with full/empty flags
module l1_derand_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // full/empty come from the registered count, so a same-cycle pop never frees a slot
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/l1_accept_readout.sv
// rtl/l1_accept_readout.sv - latency ring buffer, accept FSM, derandomiser and loss counter
// Optional zero suppression of accepted events: L1_READOUT_ZS_EN
module l1_accept_readout
    import l1_readout_pkg::*;
#(
    parameter int TRIG_LATENCY = 2,
    parameter int PIPE_DEPTH   = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int DEAD_TIME    = 3,
    parameter int BX_W         = EVT_BX_W,
    parameter logic signed [SAMPLE_W-1:0] ZS_THRESH = 8'sd8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] energy,
    input  logic [SAMPLE_W-1:0] isol,
    input  logic                trigger,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [SAMPLE_W-1:0] rd_energy,
    output logic [SAMPLE_W-1:0] rd_isol,
    output logic [BX_W-1:0]     rd_bx,
    output logic                busy,
    output logic [LOST_W-1:0]   lost_cnt
);

    localparam int PTR_W   = $clog2(PIPE_DEPTH);
    localparam int CNT_MAX = (TRIG_LATENCY > DEAD_TIME) ? TRIG_LATENCY : DEAD_TIME;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [BX_W-1:0]  bx;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] sel_ptr;
    event_t           ring [PIPE_DEPTH];
    event_t           sel_evt;
    event_t           head_evt;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             zs_pass;
    logic             push;
    logic             lost_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bx     <= '0;
            wr_ptr <= '0;
        end else begin
            bx     <= bx + BX_W'(1);
            wr_ptr <= wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        ring[wr_ptr] <= '{energy: energy, isol: isol, bx: bx};
    end

    // the sample TRIG_LATENCY cycles old was written TRIG_LATENCY slots behind wr_ptr
    assign sel_ptr = wr_ptr - PTR_W'(TRIG_LATENCY);
    assign sel_evt = ring[sel_ptr];

`ifdef L1_READOUT_ZS_EN
    assign zs_pass = ($signed(sel_evt.energy) >= ZS_THRESH);
`else
    assign zs_pass = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WARMUP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The accept cycle is the first dead-time cycle; DEAD covers the remaining DEAD_TIME-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WARMUP: begin
                if (cnt == CNT_W'(TRIG_LATENCY - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                if (trigger && !fifo_full && zs_pass && (DEAD_TIME > 1)) begin
                    state_nxt = DEAD;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            DEAD: begin
                if (cnt >= CNT_W'(DEAD_TIME - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = WARMUP;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        push     = 1'b0;
        lost_inc = 1'b0;
        case (state)
            WARMUP: lost_inc = trigger;
            IDLE: begin
                if (trigger) begin
                    if (fifo_full) begin
                        lost_inc = 1'b1;
                    end else begin
                        push = zs_pass;
                    end
                end
            end
            DEAD:    lost_inc = trigger;
            default: lost_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lost_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            if (lost_inc && (lost_cnt != LOST_MAX)) begin
                lost_cnt <= lost_cnt + LOST_W'(1);
            end
            busy <= (state == DEAD) || fifo_full;
        end
    end

    l1_derand_fifo #(
        .WIDTH ($bits(event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (sel_evt),
        .pop       (rd_ready),
        .head      (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_valid  = !fifo_empty;
    assign rd_energy = head_evt.energy;
    assign rd_isol   = head_evt.isol;
    assign rd_bx     = head_evt.bx;

endmodule
